// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for the shared 4:1 datapath bus mux: one-hot registered grant,
// registered mux select and a bounded burst length so no requester can starve the others.
module rr_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  localparam int W = $clog2(MAX_HOLD + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic         busy,
  output logic [W-1:0] hold_cnt,
  output logic [0:0]   dbg_state,
  output logic [1:0]   dbg_ptr
);

  localparam logic [0:0]   ST_IDLE  = 1'b0;
  localparam logic [0:0]   ST_GRANT = 1'b1;
  localparam logic [W-1:0] HOLD_MAX = W'(MAX_HOLD);

  logic [0:0]   state, state_n;
  logic [1:0]   ptr, ptr_n;
  logic [3:0]   gnt_n;
  logic [1:0]   sel_n;
  logic [W-1:0] hold_n;
  logic [3:0]   others;
  logic [2:0]   win;
  logic         rel;

  // Circular search from p; returns {found, index}. Scanning downward lets the
  // smallest offset from p overwrite any later match.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = sel;
    hold_n  = hold_cnt;
    others  = req & ~gnt;
    win     = 3'b000;
    rel     = 1'b0;
    if (state == ST_IDLE) begin
      win = pick(req, ptr);
      if (win[2]) begin
        state_n = ST_GRANT;
        gnt_n   = 4'b0001 << win[1:0];
        sel_n   = win[1:0];
        hold_n  = W'(1);
      end
    end else begin
      rel = !req[sel] || ((hold_cnt == HOLD_MAX) && (|others));
      if (rel) begin
        // The releasing owner is masked out for this one re-arbitration only.
        ptr_n = sel + 2'd1;
        win   = pick(others, sel + 2'd1);
        if (win[2]) begin
          gnt_n  = 4'b0001 << win[1:0];
          sel_n  = win[1:0];
          hold_n = W'(1);
        end else begin
          state_n = ST_IDLE;
          gnt_n   = 4'b0000;
          hold_n  = '0;
        end
      end else if (hold_cnt != HOLD_MAX) begin
        hold_n = hold_cnt + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= 2'd0;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      hold_cnt <= hold_n;
    end
  end

  assign busy      = (state == ST_GRANT);
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule
